// File: rtl/sipo_latch_feeder_if.sv
// Serial input / parallel latch-feeding output bundle for sipo_latch_feeder.
// Handshake: a bit transfers on a rising edge where ser_valid=1, ser_ready=1 and frame_clear=0.
interface sipo_latch_feeder_if #(
    parameter int WIDTH = 8
);
    logic             ser_valid;
    logic             ser_bit;
    logic             frame_clear;
    logic             ser_ready;
    logic [WIDTH-1:0] par_data;
    logic             latch_en;
    logic             frame_done;
    logic             busy;
    logic             overrun;

    modport master (
        output ser_valid, ser_bit, frame_clear,
        input  ser_ready, par_data, latch_en, frame_done, busy, overrun
    );

    modport slave (
        input  ser_valid, ser_bit, frame_clear,
        output ser_ready, par_data, latch_en, frame_done, busy, overrun
    );
endinterface

// File: rtl/sipo_latch_feeder.sv
// Serial-in, parallel-out frame assembler feeding a bank of transparent D latches:
// shifts WIDTH bits, then holds the word on par_data while strobing latch_en.
module sipo_latch_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int LE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    sipo_latch_feeder_if.slave  bus,
    output logic [1:0]          o_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_STROBE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_par;
    logic [WIDTH-1:0] w_sreg_next;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_scnt;
    logic             r_le;
    logic             r_ovr;
    logic             w_ready;
    logic             w_accept;
    logic             w_last;

    assign w_ready  = (r_state != S_STROBE);
    assign w_accept = bus.ser_valid & w_ready & ~bus.frame_clear;
    assign w_last   = w_accept & (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_sreg_next = r_sreg;
        if (MSB_FIRST) begin
            w_sreg_next = {r_sreg[WIDTH-2:0], bus.ser_bit};
        end else begin
            w_sreg_next = {bus.ser_bit, r_sreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (bus.frame_clear) w_next = S_IDLE;
                else if (w_last)     w_next = S_STROBE;
            end
            S_STROBE: begin
                if (r_scnt == '0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // par_data is loaded only on the completing edge, so it is stable for the whole strobe and after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
            r_par  <= '0;
            r_cnt  <= '0;
            r_scnt <= '0;
            r_le   <= 1'b0;
        end else if (r_state == S_STROBE) begin
            if (r_scnt == '0) begin
                r_le <= 1'b0;
            end else begin
                r_scnt <= r_scnt - SW'(1);
            end
        end else if (bus.frame_clear) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_sreg <= w_sreg_next;
            if (w_last) begin
                r_cnt  <= '0;
                r_par  <= w_sreg_next;
                r_le   <= 1'b1;
                r_scnt <= SW'(LE_CYCLES - 1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // frame_clear wins over a same-cycle overrun set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (bus.frame_clear) begin
            r_ovr <= 1'b0;
        end else if (bus.ser_valid && !w_ready) begin
            r_ovr <= 1'b1;
        end
    end

    assign bus.ser_ready  = w_ready;
    assign bus.par_data   = r_par;
    assign bus.latch_en   = r_le;
    assign bus.frame_done = (r_state == S_STROBE) && (r_scnt == '0);
    assign bus.busy       = (r_state == S_STROBE) || (r_cnt != '0);
    assign bus.overrun    = r_ovr;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_sipo_latch_feeder.sv
// Bench for sipo_latch_feeder: an MSB-first and an LSB-first instance receive the same
// serial stream; delivered words are scoreboarded at each latch_en rising edge.
module tb_sipo_latch_feeder;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg0;
    logic [1:0] dbg1;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp1_q[$];
    logic         prev_le[2];
    logic [W-1:0] prev_par[2];

    sipo_latch_feeder_if #(.WIDTH(W)) bus0 ();
    sipo_latch_feeder_if #(.WIDTH(W)) bus1 ();

    sipo_latch_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .LE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .o_dbg_state(dbg0)
    );
    sipo_latch_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .LE_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg1)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] rev8(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic set_in(input logic v, input logic b, input logic fc);
        bus0.ser_valid = v; bus0.ser_bit = b; bus0.frame_clear = fc;
        bus1.ser_valid = v; bus1.ser_bit = b; bus1.frame_clear = fc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit push);
        if (push) begin
            exp_q.push_back(w);
            exp1_q.push_back(rev8(w));
        end
        for (int i = W - 1; i >= 0; i--) begin
            set_in(1'b1, w[i], 1'b0);
            step();
        end
        set_in(1'b0, 1'b0, 1'b0);
    endtask

    // Called right after the edge that accepted the last bit.
    task automatic check_strobe(input logic [W-1:0] w, input string name);
        chk({name, "_le_c1"}, {bus0.latch_en, bus1.latch_en}, 2'b11);
        chk({name, "_par_msb"}, bus0.par_data, w);
        chk({name, "_par_lsb"}, bus1.par_data, rev8(w));
        chk({name, "_fd_c1"}, {bus0.frame_done, bus1.frame_done}, 2'b00);
        chk({name, "_ready_c1"}, bus0.ser_ready, 1'b0);
        chk({name, "_busy_c1"}, bus0.busy, 1'b1);
        step();
        chk({name, "_le_c2"}, {bus0.latch_en, bus1.latch_en}, 2'b11);
        chk({name, "_fd_c2"}, {bus0.frame_done, bus1.frame_done}, 2'b11);
        step();
        chk({name, "_le_after"}, {bus0.latch_en, bus1.latch_en}, 2'b00);
        chk({name, "_fd_after"}, bus0.frame_done, 1'b0);
        chk({name, "_ready_after"}, bus0.ser_ready, 1'b1);
        chk({name, "_busy_after"}, bus0.busy, 1'b0);
        chk({name, "_par_after"}, bus0.par_data, w);
    endtask

    // scoreboard: pop on latch_en rise, and par_data must hold while latch_en is high or falling
    task automatic mon(input int idx, input logic le, input logic [W-1:0] par);
        logic [W-1:0] e;
        int           sz;
        if (rst) begin
            prev_le[idx]  = 1'b0;
            prev_par[idx] = par;
        end else begin
            if (le && !prev_le[idx]) begin
                sz = (idx == 0) ? exp_q.size() : exp1_q.size();
                chk($sformatf("strobe_expected%0d", idx), sz != 0, 1'b1);
                if (sz != 0) begin
                    e = (idx == 0) ? exp_q.pop_front() : exp1_q.pop_front();
                    chk($sformatf("sb_par%0d", idx), par, e);
                end
            end else if (prev_le[idx]) begin
                chk($sformatf("par_hold%0d", idx), par, prev_par[idx]);
            end
            prev_le[idx]  = le;
            prev_par[idx] = par;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.latch_en, bus0.par_data);
        mon(1, bus1.latch_en, bus1.par_data);
    end

    initial begin
        int gap;
        logic [4:0] part;
        logic [W-1:0] gw;

        set_in(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        chk("rst_par", bus0.par_data, 8'h00);
        chk("rst_le", {bus0.latch_en, bus1.latch_en}, 2'b00);
        chk("rst_fd", bus0.frame_done, 1'b0);
        chk("rst_ovr", bus0.overrun, 1'b0);
        chk("rst_busy", bus0.busy, 1'b0);
        chk("rst_state", dbg0, 2'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {bus0.ser_ready, bus1.ser_ready}, 2'b11);
        step();

        // basic frame 1,0,1,0,0,1,0,1
        send_frame(8'hA5, 1'b1);
        check_strobe(8'hA5, "basic");

        // bit order: 1,1,0,0,0,0,0,0
        send_frame(8'hC0, 1'b1);
        check_strobe(8'hC0, "order");
        chk("order_lsb_first", bus1.par_data, 8'h03);

        // gapped 8'h3C
        gw = 8'h3C;
        exp_q.push_back(gw);
        exp1_q.push_back(rev8(gw));
        for (int i = W - 1; i >= 0; i--) begin
            set_in(1'b1, gw[i], 1'b0);
            step();
            if (i > 0) begin
                set_in(1'b0, 1'b0, 1'b0);
                gap = $urandom_range(1, 3);
                repeat (gap) begin
                    step();
                    chk("gap_busy", bus0.busy, 1'b1);
                    chk("gap_le", bus0.latch_en, 1'b0);
                end
            end
        end
        set_in(1'b0, 1'b0, 1'b0);
        check_strobe(8'h3C, "gap");

        // abort after 5 bits, frame_clear with a simultaneous valid bit
        part = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            set_in(1'b1, part[i], 1'b0);
            step();
        end
        chk("abort_busy_pre", bus0.busy, 1'b1);
        set_in(1'b1, 1'b1, 1'b1);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        chk("abort_busy", {bus0.busy, bus1.busy}, 2'b00);
        chk("abort_le", bus0.latch_en, 1'b0);
        chk("abort_ovr", bus0.overrun, 1'b0);
        chk("abort_state", dbg0, 2'd0);
        step();
        chk("abort_no_strobe", bus0.latch_en, 1'b0);
        send_frame(8'h81, 1'b1);
        check_strobe(8'h81, "abort_next");

        // overrun: bits offered during both strobe cycles are dropped
        send_frame(8'h5A, 1'b1);
        set_in(1'b1, 1'b1, 1'b0);
        chk("ovr_ready", bus0.ser_ready, 1'b0);
        step();
        chk("ovr_set", {bus0.overrun, bus1.overrun}, 2'b11);
        chk("ovr_le_c2", bus0.latch_en, 1'b1);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        chk("ovr_sticky", bus0.overrun, 1'b1);
        chk("ovr_le_after", bus0.latch_en, 1'b0);
        chk("ovr_par_kept", bus0.par_data, 8'h5A);
        chk("ovr_dropped", bus0.busy, 1'b0);

        // back-to-back 8'hFF; frame_clear in STROBE clears overrun but keeps the strobe
        send_frame(8'hFF, 1'b1);
        chk("ff_le", bus0.latch_en, 1'b1);
        chk("ff_par", {bus0.par_data, bus1.par_data}, 16'hFFFF);
        set_in(1'b1, 1'b0, 1'b1);
        step();
        chk("clr_ovr_priority", bus0.overrun, 1'b0);
        chk("clr_strobe_kept", bus0.latch_en, 1'b1);
        chk("clr_fd", bus0.frame_done, 1'b1);
        set_in(1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        chk("ovr_reset_again", bus0.overrun, 1'b1);
        chk("ff_le_after", bus0.latch_en, 1'b0);
        chk("ff_par_after", bus0.par_data, 8'hFF);

        // reset during the first strobe cycle
        send_frame(8'h66, 1'b0);
        chk("mid_le", bus0.latch_en, 1'b1);
        chk("mid_par", bus0.par_data, 8'h66);
        rst = 1'b1;
        #1;
        chk("mid_rst_le", {bus0.latch_en, bus1.latch_en}, 2'b00);
        chk("mid_rst_par", bus0.par_data, 8'h00);
        chk("mid_rst_fd", bus0.frame_done, 1'b0);
        chk("mid_rst_ovr", bus0.overrun, 1'b0);
        chk("mid_rst_state", dbg0, 2'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", bus0.ser_ready, 1'b1);
        chk("mid_rel_busy", bus0.busy, 1'b0);
        step();

        // recovery frame
        send_frame(8'h12, 1'b1);
        check_strobe(8'h12, "recover");
        step();
        chk("queue_drained", exp_q.size() + exp1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
